trig_sweep_scheduler: RTL and testbench
=======================================

# trig_sweep_scheduler

Schedules per-octave sweeps over the sin/cos lookup tables for the DFT engine. Each octave raises a sample request when it has a new input sample. The scheduler arbitrates among pending octaves round-robin and sweeps bins 0..BINS-1 for the granted octave through a valid/ready handshake to the DFT datapath. On every accepted bin it emits a one-hot counter increment, which advances that octave's table position counter for that bin.

## Interface
- `BINS`, default 24: bins per octave; number of waves in the trig tables.
- `OCTAVES`, default 5: number of octave requesters.
- `clk` input, 1 bit: single clock; all logic is posedge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `sampleReq` input, OCTAVES bits: one-cycle pulse per octave meaning "new sample, sweep all bins".
- `clearOverrun` input, 1 bit: clears all `overrun` bits on the next edge.
- `binReady` input, 1 bit: the datapath accepts the presented bin this cycle.
- `binValid` output, 1 bit: `octaveOut` and `binOut` are valid.
- `octaveOut` output, $clog2(OCTAVES) bits: octave being swept.
- `binOut` output, $clog2(BINS) bits: bin index; it drives the table and counter `bin` address.
- `lastBin` output, 1 bit: `binValid && binOut == BINS-1`.
- `counterInc` output, OCTAVES bits: one-hot; bit `octaveOut` = `binValid && binReady`. It feeds each octave's position-counter increment.
- `busy` output, 1 bit: FSM is in SWEEP.
- `overrun` output, OCTAVES bits: sticky; a request arrived while that octave was already pending.

## Operation
- State per octave:
  - `pending[o]` is set on the edge where `sampleReq[o]` is high.
  - `pending[o]` is cleared on the edge that grants octave o.
  - If set and clear land on the same edge, set wins.
- Overrun:
  - `sampleReq[o]` while `pending[o]` is already 1 and o is not being granted on that edge sets `overrun[o]`. The two requests merge; only one sweep is issued.
  - `clearOverrun` takes priority over a simultaneous overrun set.
- Arbitration is round-robin over registered `pending`.
  - The search starts at `(lastGrant+1) mod OCTAVES`.
  - `lastGrant` resets to OCTAVES-1, so octave 0 wins first after reset.
- FSM states:
  - IDLE: if any `pending`, grant winner g; `octaveOut<=g`, `binOut<=0`, `binValid<=1`, `lastGrant<=g`, go to SWEEP. Otherwise stay in IDLE with `binValid=0`.
  - SWEEP, handshake (`binValid && binReady`) with `binOut < BINS-1`: `binOut<=binOut+1`.
  - SWEEP, handshake with `binOut == BINS-1`: if any `pending` on that edge, grant the next winner as in IDLE and stay in SWEEP with no bubble. Otherwise `binValid<=0` and go to IDLE.
  - SWEEP, no handshake: hold all outputs stable.
- Outputs never change while `binValid && !binReady`.
- `binOut` never exceeds BINS-1 and does not wrap inside a sweep. Exactly BINS `counterInc` pulses are issued per grant.
- An octave already in SWEEP can be re-requested; it is then pending and eligible at sweep end.
- Reset values: `binValid=0`, `octaveOut=0`, `binOut=0`, `busy=0`, `counterInc=0`, `overrun=0`, `pending=0`, state IDLE.
- Reset mid-sweep aborts the sweep. No `counterInc` is asserted on the reset cycle, and requests on the reset cycle are dropped.

## Timing
- `sampleReq` pulse before edge k → `pending` high after edge k → grant at edge k+1 → `binValid=1`, `binOut=0` in cycle k+1. Minimum request-to-valid latency is 2 edges.
- With `binReady` held high, one bin is issued per cycle. A sweep occupies BINS cycles.
- Back-to-back sweeps have zero idle cycles.
- `counterInc` and `lastBin` are combinational from registered state and `binReady`. The counters see the increment on the same edge the datapath accepts the bin.

## Test plan
- Single sweep, OCTAVES=5, BINS=24:
  - Stimulus: `sampleReq=5'b00100` in cycle 0, `binReady=1`.
  - Required response: `binValid` high in cycles 2–25, `octaveOut=2`, `binOut` 0..23, `lastBin` only in cycle 25, `counterInc=5'b00100` for 24 cycles, idle in cycle 26.
- Simultaneous requests:
  - Stimulus: `sampleReq=5'b10011` in one cycle.
  - Required response: sweeps in order octave 0, 1, 4, back-to-back, 72 consecutive valid cycles, no `overrun`.
- Backpressure:
  - Stimulus: drop `binReady` for 3 cycles at `binOut=7`.
  - Required response: `binOut` holds at 7, `counterInc=0` during the stall, the sweep completes with exactly 24 increments.
- Overrun:
  - Stimulus: `sampleReq[1]` twice while octave 0 is sweeping.
  - Required response: `overrun=5'b00010` and only one octave-1 sweep. `clearOverrun` returns `overrun` to 0.
- Round-robin fairness:
  - Stimulus: re-request octave 0 at the end of every sweep while octave 3 is pending.
  - Required response: octave 3 is granted after the current octave-0 sweep and is never starved.
- Reset mid-sweep:
  - Stimulus: assert `rst` at `binOut=10` with octave 2 pending.
  - Required response: next cycle all outputs are at reset values and `pending=0`. A fresh request then sweeps from bin 0.

Source files
------------

// File: rtl/trig_sweep_scheduler.sv
// Round-robin sweep scheduler: grants pending octaves and walks bins 0..BINS-1
// over a valid/ready handshake, emitting a one-hot position-counter increment.
module trig_sweep_scheduler #(
  parameter int BINS    = 24,
  parameter int OCTAVES = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [OCTAVES-1:0]           sampleReq,
  input  logic                         clearOverrun,
  input  logic                         binReady,
  output logic                         binValid,
  output logic [$clog2(OCTAVES)-1:0]   octaveOut,
  output logic [$clog2(BINS)-1:0]      binOut,
  output logic                         lastBin,
  output logic [OCTAVES-1:0]           counterInc,
  output logic                         busy,
  output logic [OCTAVES-1:0]           overrun
);
  localparam int OW = $clog2(OCTAVES);
  localparam int BW = $clog2(BINS);
  localparam logic [BW-1:0] LAST_BIN = BW'(BINS - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t              state_q, state_d;
  logic [OCTAVES-1:0]  pending_q, pending_d;
  logic [OCTAVES-1:0]  overrun_q, overrun_d;
  logic [OW-1:0]       last_grant_q, last_grant_d;
  logic [OW-1:0]       octave_q, octave_d;
  logic [BW-1:0]       bin_q, bin_d;
  logic                valid_q, valid_d;
  logic [OCTAVES-1:0]  grant_vec;
  logic [OW-1:0]       winner;
  logic                handshake;

  assign handshake = valid_q && binReady;

  // Round-robin search starting one past the last granted octave.
  always_comb begin
    int  idx;
    logic found;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 1; i <= OCTAVES; i++) begin
      idx = int'(last_grant_q) + i;
      if (idx >= OCTAVES) idx = idx - OCTAVES;
      if (!found && pending_q[idx]) begin
        winner = idx[OW-1:0];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    octave_d     = octave_q;
    bin_d        = bin_q;
    valid_d      = valid_q;
    last_grant_d = last_grant_q;
    grant_vec    = '0;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          grant_vec    = OCTAVES'(1) << winner;
          octave_d     = winner;
          bin_d        = '0;
          valid_d      = 1'b1;
          last_grant_d = winner;
          state_d      = SWEEP;
        end
      end
      SWEEP: begin
        if (handshake) begin
          if (bin_q != LAST_BIN) begin
            bin_d = bin_q + 1'b1;
          end else if (|pending_q) begin
            // Chain straight into the next sweep without a bubble.
            grant_vec    = OCTAVES'(1) << winner;
            octave_d     = winner;
            bin_d        = '0;
            last_grant_d = winner;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A new request beats a same-edge grant clear; clearOverrun beats a new overrun.
    pending_d = (pending_q & ~grant_vec) | sampleReq;
    overrun_d = clearOverrun ? '0 : (overrun_q | (sampleReq & pending_q & ~grant_vec));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      overrun_q    <= '0;
      last_grant_q <= OW'(OCTAVES - 1);
      octave_q     <= '0;
      bin_q        <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      last_grant_q <= last_grant_d;
      octave_q     <= octave_d;
      bin_q        <= bin_d;
      valid_q      <= valid_d;
    end
  end

  assign binValid   = valid_q;
  assign octaveOut  = octave_q;
  assign binOut     = bin_q;
  assign lastBin    = valid_q && (bin_q == LAST_BIN);
  assign counterInc = (handshake && !rst) ? (OCTAVES'(1) << octave_q) : '0;
  assign busy       = (state_q == SWEEP);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_trig_sweep_scheduler.sv
// Scoreboard bench for trig_sweep_scheduler: a transaction-level model predicts
// every accepted (octave, bin) pair; a negedge monitor pops and compares.
module tb_trig_sweep_scheduler;
  localparam int BINS    = 24;
  localparam int OCTAVES = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [OCTAVES-1:0]  sampleReq;
  logic                clearOverrun;
  logic                binReady;
  logic                binValid;
  logic [2:0]          octaveOut;
  logic [4:0]          binOut;
  logic                lastBin;
  logic [OCTAVES-1:0]  counterInc;
  logic                busy;
  logic [OCTAVES-1:0]  overrun;

  trig_sweep_scheduler #(.BINS(BINS), .OCTAVES(OCTAVES)) dut (
    .clk(clk), .rst(rst), .sampleReq(sampleReq), .clearOverrun(clearOverrun),
    .binReady(binReady), .binValid(binValid), .octaveOut(octaveOut), .binOut(binOut),
    .lastBin(lastBin), .counterInc(counterInc), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit started = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending set, round-robin pointer, one active sweep with a
  // count of bins still to be accepted.
  bit         m_pend [OCTAVES];
  bit         m_ovr  [OCTAVES];
  int         m_last;
  bit         m_active;
  int         m_left;
  int         q_oct[$];
  int         q_bin[$];

  function automatic int ovr_word();
    int w = 0;
    for (int o = 0; o < OCTAVES; o++) if (m_ovr[o]) w |= (1 << o);
    return w;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < OCTAVES; o++) begin m_pend[o] = 0; m_ovr[o] = 0; end
      m_last = OCTAVES - 1; m_active = 0; m_left = 0;
      q_oct.delete(); q_bin.delete();
    end else begin
      int  g;
      bit  ended;
      g = -1; ended = 0;
      if (m_active && binReady) begin
        m_left--;
        if (m_left == 0) ended = 1;
      end
      if (!m_active || ended) begin
        for (int i = 1; i <= OCTAVES; i++)
          if (g < 0 && m_pend[(m_last + i) % OCTAVES]) g = (m_last + i) % OCTAVES;
        if (g >= 0) begin
          m_active = 1; m_left = BINS; m_last = g;
          for (int b = 0; b < BINS; b++) begin q_oct.push_back(g); q_bin.push_back(b); end
        end else m_active = 0;
      end
      for (int o = 0; o < OCTAVES; o++) begin
        if (sampleReq[o] && m_pend[o] && o != g) m_ovr[o] = 1;
        if (clearOverrun) m_ovr[o] = 0;
        if (o == g) m_pend[o] = 0;
        if (sampleReq[o]) m_pend[o] = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      if (rst) chk("inc_on_reset", counterInc, 0);
      else begin
        chk("binValid", binValid, m_active);
        chk("busy", busy, m_active);
        chk("overrun", overrun, ovr_word());
        if (binValid && binReady) begin
          if (q_oct.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_bin: got octave %0d bin %0d expected none", octaveOut, binOut);
          end else begin
            int eo, eb;
            eo = q_oct.pop_front(); eb = q_bin.pop_front();
            chk("octaveOut", octaveOut, eo);
            chk("binOut", binOut, eb);
            chk("counterInc", counterInc, 1 << eo);
            chk("lastBin", lastBin, (eb == BINS - 1) ? 1 : 0);
          end
        end else begin
          chk("inc_idle", counterInc, 0);
          if (!binValid) chk("lastBin_idle", lastBin, 0);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_req(input logic [OCTAVES-1:0] r);
    sampleReq = r; step(); sampleReq = '0;
  endtask

  task automatic wait_bin(input int oct, input int b, input string name);
    int n = 0;
    while (!(binValid && octaveOut == oct && binOut == b) && n < 400) begin step(); n++; end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s: timeout waiting for octave %0d bin %0d", name, oct, b);
    end
  endtask

  initial begin
    rst = 1; sampleReq = '0; clearOverrun = 0; binReady = 1;
    started = 1;
    step(3);
    rst = 0;
    chk("rst_binValid", binValid, 0);
    chk("rst_octaveOut", octaveOut, 0);
    chk("rst_binOut", binOut, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);

    // Single sweep of octave 2
    pulse_req(5'b00100);
    chk("single_latency1", binValid, 0);
    step();
    chk("single_valid", binValid, 1);
    chk("single_oct", octaveOut, 2);
    step(30);

    // Simultaneous requests: 0, 1, 4 back-to-back
    pulse_req(5'b10011);
    step(80);

    // Backpressure at bin 7
    pulse_req(5'b00010);
    wait_bin(1, 7, "bp_reach7");
    binReady = 0;
    step(3);
    chk("bp_hold_bin", binOut, 7);
    chk("bp_hold_inc", counterInc, 0);
    binReady = 1;
    step(30);

    // Overrun: octave 1 requested twice while octave 0 sweeps
    pulse_req(5'b00001);
    step(4);
    pulse_req(5'b00010);
    step(2);
    pulse_req(5'b00010);
    step();
    chk("overrun_set", overrun, 5'b00010);
    step(60);
    clearOverrun = 1; step(); clearOverrun = 0;
    chk("overrun_clear", overrun, 0);

    // Fairness: octave 0 re-requested at every sweep end while 3 waits
    pulse_req(5'b00001);
    step(3);
    pulse_req(5'b01000);
    for (int k = 0; k < 4; k++) begin
      while (!lastBin) step();
      pulse_req(5'b00001);
    end
    step(60);

    // Reset mid-sweep with octave 2 pending
    pulse_req(5'b00100);
    wait_bin(2, 3, "rst_reach3");
    pulse_req(5'b00100);
    wait_bin(2, 10, "rst_reach10");
    rst = 1; sampleReq = 5'b00001; step(); rst = 0; sampleReq = '0;
    chk("midrst_valid", binValid, 0);
    chk("midrst_bin", binOut, 0);
    chk("midrst_oct", octaveOut, 0);
    step(3);
    chk("midrst_no_pending", binValid, 0);
    pulse_req(5'b01000);
    step();
    chk("fresh_oct", octaveOut, 3);
    chk("fresh_bin", binOut, 0);
    step(30);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int o = 0; o < OCTAVES; o++) sampleReq[o] = ($urandom_range(0, 59) == 0);
      binReady     = ($urandom_range(0, 3) != 0);
      clearOverrun = ($urandom_range(0, 99) == 0);
      step();
    end
    sampleReq = '0; clearOverrun = 0; binReady = 1;
    begin
      int n = 0;
      while ((binValid || q_oct.size() != 0) && n < 1000) begin step(); n++; end
    end
    step(3);
    chk("drain_queue_empty", q_oct.size(), 0);
    chk("drain_idle", binValid, 0);

    started = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
